decode_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline; consumes the fetch stage's IF/ID outputs (instruction, PC).
- Returns the redirect interface to fetch: j_label, b_label, zero, b_address, j_address, plus a stall.
- Holds the 32x32 register file, load-use/branch hazard detection, and the ID/EX pipeline register.
- Branches and jumps resolve in ID; there is no delay slot, so the wrong-path instruction is squashed.

---
 rtl/decode_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction-decode stage of a 5-stage MIPS pipeline.
//                Decodes the IF/ID word, reads the 32-entry register file
//                (write-through from writeback), detects load-use and branch
//                operand hazards, resolves beq/bne/j in ID (no delay slot),
//                and drives the ID/EX pipeline register.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                instruction, PC_in       - IF/ID word and its PC
//                wb_we, wb_addr, wb_data  - register file write port
//                ex_reg_write, ex_mem_read, ex_dest  - EX-stage hazard info
//                mem_reg_write, mem_dest  - MEM-stage hazard info
//                stall                    - hold PC and IF/ID
//                j_label, b_label, zero   - redirect controls to fetch
//                b_address, j_address     - raw branch/jump target fields
//                id_ex_*                  - ID/EX pipeline register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       PC_in,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dest,
    output logic              stall,
    output logic              j_label,
    output logic              b_label,
    output logic              zero,
    output logic [15:0]       b_address,
    output logic [25:0]       j_address,
    output logic [DATA_W-1:0] id_ex_rs_data,
    output logic [DATA_W-1:0] id_ex_rt_data,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [REG_AW-1:0] id_ex_rt,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic [31:0]       id_ex_pc,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write,
    output logic              id_ex_mem_to_reg,
    output logic              id_ex_alu_src,
    output logic              id_ex_reg_dst,
    output logic [3:0]        id_ex_alu_op
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_SLT  = 4'd4;

    localparam int c_NREGS = 1 << REG_AW;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_imm;

    assign w_opcode  = instruction[31:26];
    assign w_funct   = instruction[5:0];
    assign w_rs      = instruction[25:21];
    assign w_rt      = instruction[20:16];
    assign w_rd      = instruction[15:11];
    assign w_imm     = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    assign b_address = instruction[15:0];
    assign j_address = instruction[25:0];

    // ------------------------------------------------------------------
    // Register file with write-through reads
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_rs != '0) begin
            w_rs_data = (wb_we && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
        end
        if (w_rt != '0) begin
            w_rt_data = (wb_we && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];
        end
    end

    // ------------------------------------------------------------------
    // Decode. w_valid=0 means the word decodes as a bubble.
    // ------------------------------------------------------------------
    logic       w_valid;
    logic       w_rt_src;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_alu_src;
    logic       w_reg_dst;
    logic [3:0] w_alu_op;

    always_comb begin
        w_valid      = 1'b0;
        w_rt_src     = 1'b0;
        w_is_branch  = 1'b0;
        w_is_jump    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_op     = c_ALU_ADD;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_rt_src = 1'b1;
                case (w_funct)
                    c_FN_ADD: begin w_valid = 1'b1; w_alu_op = c_ALU_ADD; end
                    c_FN_SUB: begin w_valid = 1'b1; w_alu_op = c_ALU_SUB; end
                    c_FN_AND: begin w_valid = 1'b1; w_alu_op = c_ALU_AND; end
                    c_FN_OR:  begin w_valid = 1'b1; w_alu_op = c_ALU_OR;  end
                    c_FN_SLT: begin w_valid = 1'b1; w_alu_op = c_ALU_SLT; end
                    default:  ;
                endcase
                w_reg_dst   = w_valid;
                w_reg_write = w_valid;
            end
            c_OP_ADDI: begin
                w_valid     = 1'b1;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_LW: begin
                w_valid      = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            c_OP_SW: begin
                w_valid     = 1'b1;
                w_rt_src    = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_valid     = 1'b1;
                w_rt_src    = 1'b1;
                w_is_branch = 1'b1;
            end
            c_OP_J: begin
                w_valid   = 1'b1;
                w_is_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Hazards, squash and redirects
    // ------------------------------------------------------------------
    logic r_squash;
    logic w_load_use;
    logic w_branch_haz;
    logic w_stall;
    logic w_kill;
    logic w_cond;

    assign w_load_use = ex_mem_read && (ex_dest != '0) &&
                        ((ex_dest == w_rs) || (w_rt_src && (ex_dest == w_rt)));

    // Branches compare in ID, so any in-flight producer of an operand blocks them.
    assign w_branch_haz = w_is_branch &&
        ((ex_reg_write  && (ex_dest  != '0) && ((ex_dest  == w_rs) || (ex_dest  == w_rt))) ||
         (mem_reg_write && (mem_dest != '0) && ((mem_dest == w_rs) || (mem_dest == w_rt))));

    assign w_stall = (w_load_use || w_branch_haz) && !r_squash && !rst;
    assign w_kill  = w_stall || r_squash || rst;

    assign w_cond  = (w_opcode == c_OP_BEQ) ? (w_rs_data == w_rt_data)
                                            : (w_rs_data != w_rt_data);

    assign stall   = w_stall;
    assign j_label = w_is_jump   && !w_kill;
    assign b_label = w_is_branch && !w_kill;
    assign zero    = w_is_branch && w_cond && !w_kill;

    // The word fetched after a taken redirect is the wrong path; drop it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_squash <= 1'b0;
        end else begin
            r_squash <= j_label || (b_label && zero);
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_kill || !w_valid) begin
            id_ex_rs_data    <= '0;
            id_ex_rt_data    <= '0;
            id_ex_imm        <= '0;
            id_ex_rt         <= '0;
            id_ex_rd         <= '0;
            id_ex_pc         <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_reg_dst    <= 1'b0;
            id_ex_alu_op     <= '0;
        end else begin
            id_ex_rs_data    <= w_rs_data;
            id_ex_rt_data    <= w_rt_data;
            id_ex_imm        <= w_imm;
            id_ex_rt         <= w_rt;
            id_ex_rd         <= w_rd;
            id_ex_pc         <= PC_in;
            id_ex_reg_write  <= w_reg_write;
            id_ex_mem_read   <= w_mem_read;
            id_ex_mem_write  <= w_mem_write;
            id_ex_mem_to_reg <= w_mem_to_reg;
            id_ex_alu_src    <= w_alu_src;
            id_ex_reg_dst    <= w_reg_dst;
            id_ex_alu_op     <= w_alu_op;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage. Expected ID/EX
//                contents come from a small decode/register-file model and are
//                queued when stimulus is driven, then popped after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, PC_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_reg_write, ex_mem_read, mem_reg_write;
    logic [4:0]  ex_dest, mem_dest;
    logic        stall, j_label, b_label, zero;
    logic [15:0] b_address;
    logic [25:0] j_address;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc;
    logic [4:0]  id_ex_rt, id_ex_rd;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic        id_ex_mem_to_reg, id_ex_alu_src, id_ex_reg_dst;
    logic [3:0]  id_ex_alu_op;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .PC_in(PC_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .stall(stall), .j_label(j_label), .b_label(b_label), .zero(zero),
        .b_address(b_address), .j_address(j_address),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_pc(id_ex_pc), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_dst(id_ex_reg_dst), .id_ex_alu_op(id_ex_alu_op)
    );

    typedef struct packed {
        logic [31:0] rs_data, rt_data, imm, pc;
        logic [4:0]  rt, rd;
        logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
        logic [3:0]  alu_op;
    } idex_t;

    idex_t       dut_idex;
    idex_t       sb_q[$];
    logic [31:0] model_rf [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign dut_idex = {id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc, id_ex_rt, id_ex_rd,
                       id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
                       id_ex_alu_src, id_ex_reg_dst, id_ex_alu_op};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return model_rf[a];
    endfunction

    function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        idex_t e = '0;
        logic  valid = 1'b1;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: e.alu_op = 4'd0;
                    6'h22: e.alu_op = 4'd1;
                    6'h24: e.alu_op = 4'd2;
                    6'h25: e.alu_op = 4'd3;
                    6'h2A: e.alu_op = 4'd4;
                    default: valid = 1'b0;
                endcase
                e.reg_dst = 1'b1; e.reg_write = 1'b1;
            end
            6'h08: begin e.alu_src = 1'b1; e.reg_write = 1'b1; end
            6'h23: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            6'h2B: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
            6'h02, 6'h04, 6'h05: ;
            default: valid = 1'b0;
        endcase
        if (!valid) return '0;
        e.rs_data = rd_model(ins[25:21]);
        e.rt_data = rd_model(ins[20:16]);
        e.imm     = {{16{ins[15]}}, ins[15:0]};
        e.pc      = pc;
        e.rt      = ins[20:16];
        e.rd      = ins[15:11];
        return e;
    endfunction

    // One cycle: check redirects/stall ({stall,j,b,zero}), queue the expected
    // ID/EX word, clock, update the register model, pop and compare.
    task automatic cycle(input string tag, input logic bubble, input logic [3:0] exp_comb);
        idex_t e;
        #1;
        chk({tag, "/comb"}, 160'({stall, j_label, b_label, zero}), 160'(exp_comb));
        sb_q.push_back(bubble ? idex_t'('0) : model_decode(instruction, PC_in));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            model_rf[wb_addr] = wb_data;
        end
        #1;
        e = sb_q.pop_front();
        chk({tag, "/idex"}, 160'(dut_idex), 160'(e));
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] pc);
        instruction = ins;
        PC_in       = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        // Reset with busy, arbitrary inputs
        rst = 1'b1;
        drv(32'h012A4020, 32'h0000_0040);
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd9;
        mem_reg_write = 1'b1; mem_dest = 5'd10;
        cycle("reset0", 1'b1, 4'b0000);
        drv(32'h08000040, 32'h0000_0044);
        cycle("reset1", 1'b1, 4'b0000);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
        mem_reg_write = 1'b0; mem_dest = 5'd0;

        drv(32'h00221820, 32'h100); cycle("add_after_reset", 1'b0, 4'b0000);
        wb(1'b1, 5'd5, 32'h1234);
        drv(32'h00A61820, 32'h104); cycle("write_through", 1'b0, 4'b0000);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        drv(32'h00051820, 32'h108); cycle("r0_protect", 1'b0, 4'b0000);
        wb(1'b1, 5'd1, 32'd7);
        drv(32'h00000000, 32'h10C); cycle("invalid_funct", 1'b0, 4'b0000);
        wb(1'b1, 5'd2, 32'd7);
        cycle("invalid_funct2", 1'b0, 4'b0000);
        wb(1'b0, 5'd0, 32'd0);

        // Load-use hazards
        ex_mem_read = 1'b1; ex_dest = 5'd5;
        drv(32'h00A61820, 32'h110); cycle("load_use_rs", 1'b1, 4'b1000);
        ex_mem_read = 1'b0;
        cycle("load_use_release", 1'b0, 4'b0000);
        ex_mem_read = 1'b1;
        drv(32'hAC25FFFC, 32'h114); cycle("load_use_sw_rt", 1'b1, 4'b1000);
        drv(32'h8C250008, 32'h118); cycle("lw_rt_not_src", 1'b0, 4'b0000);
        ex_mem_read = 1'b0; ex_dest = 5'd0;
        drv(32'h00222022, 32'h11C); cycle("sub", 1'b0, 4'b0000);
        drv(32'h0022202A, 32'h120); cycle("slt", 1'b0, 4'b0000);
        drv(32'h00222025, 32'h124); cycle("or", 1'b0, 4'b0000);
        drv(32'h2025FFF0, 32'h128); cycle("addi", 1'b0, 4'b0000);

        // Taken beq, squashed slot, normal decode
        drv(32'h10220004, 32'h200);
        #1 chk("beq_b_address", 160'(b_address), 160'(16'h0004));
        cycle("beq_taken", 1'b0, 4'b0011);
        drv(32'h012A4020, 32'h204); cycle("beq_squash", 1'b1, 4'b0000);
        cycle("after_squash", 1'b0, 4'b0000);

        // Jump
        drv(32'h08000040, 32'h300);
        #1 chk("j_address", 160'(j_address), 160'(26'h0000040));
        cycle("jump", 1'b0, 4'b0100);
        drv(32'h00221820, 32'h304); cycle("jump_squash", 1'b1, 4'b0000);
        cycle("after_jump", 1'b0, 4'b0000);

        // Branch hazards on bne r1,r2
        drv(32'h14220004, 32'h400);
        ex_reg_write = 1'b1; ex_dest = 5'd1;
        cycle("bne_ex_haz", 1'b1, 4'b1000);
        ex_reg_write = 1'b0; ex_dest = 5'd0;
        mem_reg_write = 1'b1; mem_dest = 5'd2;
        cycle("bne_mem_haz", 1'b1, 4'b1000);
        mem_reg_write = 1'b0; mem_dest = 5'd0;
        cycle("bne_not_taken", 1'b0, 4'b0010);
        drv(32'h00221820, 32'h404); cycle("after_untaken", 1'b0, 4'b0000);

        // Write-through feeds the branch compare: r2 becomes 9
        wb(1'b1, 5'd2, 32'd9);
        drv(32'h10220004, 32'h500); cycle("beq_wt_untaken", 1'b0, 4'b0010);
        wb(1'b0, 5'd0, 32'd0);
        drv(32'h14220004, 32'h504); cycle("bne_taken", 1'b0, 4'b0011);

        // Reset during the squash slot discards it
        rst = 1'b1;
        drv(32'h012A4020, 32'h508); cycle("reset_mid_squash", 1'b1, 4'b0000);
        rst = 1'b0;
        cycle("after_reset_no_squash", 1'b0, 4'b0000);
        drv(32'h00221820, 32'h50C); cycle("regs_cleared", 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
